// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C controller between NUM_REQ clients
module i2c_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_error,
    output logic                          rsp_timeout,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic [ADDR_WIDTH-1:0]         ctrl_slave_addr,
    output logic [DATA_WIDTH-1:0]         ctrl_tx_data,
    output logic                          ctrl_ready,
    input  logic [DATA_WIDTH-1:0]         ctrl_rx_data,
    input  logic                          ctrl_valid,
    input  logic                          ctrl_busy,
    input  logic                          ctrl_ack_error
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_ACTIVE,
        S_RESPOND
    } state_t;

    state_t                 state, state_d;
    logic [ID_W-1:0]        last_grant, last_grant_d;
    logic [ID_W-1:0]        grant_id_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [DATA_WIDTH-1:0]  capture, capture_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [NUM_REQ-1:0]     req_ready_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_d;
    logic                   rsp_error_d, rsp_timeout_d, ctrl_ready_d, arb_busy_d;
    logic [ID_W-1:0]        pick;

    // First requesting client strictly after the previous grant, wrapping to 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req_valid, last_grant);

    always_comb begin
        state_d       = state;
        last_grant_d  = last_grant;
        grant_id_d    = grant_id;
        cnt_d         = cnt;
        capture_d     = capture;
        addr_d        = ctrl_slave_addr;
        data_d        = ctrl_tx_data;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data;
        rsp_error_d   = rsp_error;
        rsp_timeout_d = rsp_timeout;
        ctrl_ready_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((|req_valid) && !ctrl_busy) begin
                    grant_id_d        = pick;
                    addr_d            = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d            = req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    capture_d         = '0;
                    req_ready_d[pick] = 1'b1;
                    ctrl_ready_d      = 1'b1;
                    state_d           = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d        = '0;
                ctrl_ready_d = 1'b1;
                state_d      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (ctrl_busy) begin
                    state_d = S_ACTIVE;
                end else if (cnt >= CNT_W'(START_TIMEOUT - 1)) begin
                    // Counter reaches START_TIMEOUT on this cycle; respond next.
                    state_d               = S_RESPOND;
                    rsp_valid_d[grant_id] = 1'b1;
                    rsp_data_d            = capture;
                    rsp_error_d           = 1'b1;
                    rsp_timeout_d         = 1'b1;
                end else begin
                    ctrl_ready_d = 1'b1;
                    cnt_d        = (cnt == CNT_W'(START_TIMEOUT)) ? cnt : cnt + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ctrl_valid) capture_d = ctrl_rx_data;
                if (!ctrl_busy) begin
                    state_d               = S_RESPOND;
                    rsp_valid_d[grant_id] = 1'b1;
                    rsp_data_d            = ctrl_valid ? ctrl_rx_data : capture;
                    rsp_error_d           = ctrl_ack_error;
                    rsp_timeout_d         = 1'b0;
                end
            end
            S_RESPOND: begin
                last_grant_d = grant_id;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            last_grant      <= ID_W'(NUM_REQ - 1);
            grant_id        <= '0;
            cnt             <= '0;
            capture         <= '0;
            ctrl_slave_addr <= '0;
            ctrl_tx_data    <= '0;
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_error       <= 1'b0;
            rsp_timeout     <= 1'b0;
            ctrl_ready      <= 1'b0;
            arb_busy        <= 1'b0;
        end else begin
            state           <= state_d;
            last_grant      <= last_grant_d;
            grant_id        <= grant_id_d;
            cnt             <= cnt_d;
            capture         <= capture_d;
            ctrl_slave_addr <= addr_d;
            ctrl_tx_data    <= data_d;
            req_ready       <= req_ready_d;
            rsp_valid       <= rsp_valid_d;
            rsp_data        <= rsp_data_d;
            rsp_error       <= rsp_error_d;
            rsp_timeout     <= rsp_timeout_d;
            ctrl_ready      <= ctrl_ready_d;
            arb_busy        <= arb_busy_d;
        end
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;
    logic        clk, rst_n;
    logic [3:0]  req_valid, req_ready, rsp_valid;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  rsp_data, ctrl_tx_data, ctrl_rx_data;
    logic        rsp_error, rsp_timeout, arb_busy, ctrl_ready;
    logic [1:0]  grant_id;
    logic [6:0]  ctrl_slave_addr;
    logic        ctrl_valid, ctrl_busy, ctrl_ack_error;

    int checks   = 0;
    int failures = 0;

    i2c_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(7), .DATA_WIDTH(8), .START_TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .grant_id(grant_id),
        .arb_busy(arb_busy), .ctrl_slave_addr(ctrl_slave_addr), .ctrl_tx_data(ctrl_tx_data),
        .ctrl_ready(ctrl_ready), .ctrl_rx_data(ctrl_rx_data), .ctrl_valid(ctrl_valid),
        .ctrl_busy(ctrl_busy), .ctrl_ack_error(ctrl_ack_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_client(input int i, input logic [6:0] a, input logic [7:0] d);
        req_addr[i*7 +: 7] = a;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (|req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Bench controller: entered on the cycle req_ready is visible, returns with RESPOND visible.
    task automatic serve(input int busy_dly, input bit give_data, input logic [7:0] rx,
                         input bit same_cycle, input bit ack);
        repeat (busy_dly) tick();
        ctrl_busy = 1'b1;
        tick();
        if (give_data && !same_cycle) begin
            ctrl_valid = 1'b1; ctrl_rx_data = rx;
            tick();
            ctrl_valid = 1'b0; ctrl_rx_data = 8'hEE;
        end
        ctrl_busy = 1'b0;
        ctrl_ack_error = ack;
        if (give_data && same_cycle) begin
            ctrl_valid = 1'b1; ctrl_rx_data = rx;
        end
        tick();
        ctrl_valid = 1'b0; ctrl_rx_data = 8'hEE; ctrl_ack_error = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if ({req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout} !== 19'd0) begin failures++; $display("FAIL reset_rsp: got %h exp 0", {req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout}); end
        checks++; if ({grant_id, arb_busy, ctrl_ready, ctrl_slave_addr, ctrl_tx_data} !== 19'd0) begin failures++; $display("FAIL reset_ctrl: got %h exp 0", {grant_id, arb_busy, ctrl_ready, ctrl_slave_addr, ctrl_tx_data}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit early = 1'b0;
        set_client(2, 7'h50, 8'hA5);
        req_valid = 4'b0100;
        tick();
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant: got %0d exp 2", grant_id); end
        checks++; if ({ctrl_ready, arb_busy} !== 2'b11) begin failures++; $display("FAIL single_launch: got %b exp 11", {ctrl_ready, arb_busy}); end
        req_valid = 4'b0000;
        tick();
        early |= |rsp_valid;
        checks++; if ({req_ready, ctrl_ready} !== 5'b00001) begin failures++; $display("FAIL single_pulse: got %b exp 00001", {req_ready, ctrl_ready}); end
        tick(); early |= |rsp_valid;
        tick(); early |= |rsp_valid;
        ctrl_busy = 1'b1;
        tick(); early |= |rsp_valid;
        checks++; if (ctrl_ready !== 1'b0) begin failures++; $display("FAIL single_ready_drop: got %b exp 0", ctrl_ready); end
        ctrl_valid = 1'b1; ctrl_rx_data = 8'h3C;
        tick(); early |= |rsp_valid;
        ctrl_valid = 1'b0; ctrl_rx_data = 8'hEE; ctrl_busy = 1'b0;
        tick();
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL single_early_rsp: got %b exp 0", early); end
        checks++; if ({rsp_valid, rsp_data, rsp_error, rsp_timeout} !== {4'b0100, 8'h3C, 2'b00}) begin failures++; $display("FAIL single_rsp: got %h exp %h", {rsp_valid, rsp_data, rsp_error, rsp_timeout}, {4'b0100, 8'h3C, 2'b00}); end
        checks++; if ({ctrl_slave_addr, ctrl_tx_data} !== {7'h50, 8'hA5}) begin failures++; $display("FAIL single_stable: got %h exp %h", {ctrl_slave_addr, ctrl_tx_data}, {7'h50, 8'hA5}); end
        tick();
        checks++; if ({rsp_valid, arb_busy} !== 5'b00000) begin failures++; $display("FAIL single_idle: got %b exp 00000", {rsp_valid, arb_busy}); end
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        bit ok;
        test_reset();
        for (int i = 0; i < 4; i++) set_client(i, 7'(8'h10 + i), 8'(8'h20 + i));
        req_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_grant(ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_wait[%0d]: no grant within bound", k); end
            checks++; if ({grant_id, req_ready} !== {2'(exp_order[k]), 4'(1 << exp_order[k])}) begin failures++; $display("FAIL rr_grant[%0d]: got id %0d ready %b exp id %0d", k, grant_id, req_ready, exp_order[k]); end
            checks++; if (ctrl_slave_addr !== 7'(8'h10 + exp_order[k])) begin failures++; $display("FAIL rr_addr[%0d]: got %h exp %h", k, ctrl_slave_addr, 7'(8'h10 + exp_order[k])); end
            if (k == 5) req_valid = 4'b0000;
            serve(1, 1'b0, 8'h00, 1'b0, 1'b0);
            if (k == 5) req_valid = 4'b0000;
            checks++; if (rsp_valid !== 4'(1 << exp_order[k])) begin failures++; $display("FAIL rr_rsp[%0d]: got %b exp %b", k, rsp_valid, 4'(1 << exp_order[k])); end
        end
        req_valid = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_ack_error();
        bit ok;
        set_client(1, 7'h22, 8'h11);
        req_valid = 4'b0010;
        wait_grant(ok);
        req_valid = 4'b0000;
        checks++; if (!ok || grant_id !== 2'd1) begin failures++; $display("FAIL ack_grant: got ok %b id %0d exp 1", ok, grant_id); end
        serve(2, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({rsp_valid, rsp_data, rsp_error, rsp_timeout} !== {4'b0010, 8'h00, 2'b10}) begin failures++; $display("FAIL ack_rsp: got %h exp %h", {rsp_valid, rsp_data, rsp_error, rsp_timeout}, {4'b0010, 8'h00, 2'b10}); end
        tick(); tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int bad_ready = 0;
        bit early = 1'b0;
        set_client(0, 7'h33, 8'h44);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL to_ready: got %b exp 0001", req_ready); end
        for (int k = 1; k <= 11; k++) begin
            if (ctrl_ready !== 1'b1) bad_ready++;
            early |= |rsp_valid;
            tick();
        end
        checks++; if (bad_ready !== 0) begin failures++; $display("FAIL to_ctrl_ready: low on %0d cycles exp 0", bad_ready); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early_rsp: got %b exp 0", early); end
        checks++; if ({rsp_valid, rsp_error, rsp_timeout, ctrl_ready} !== 7'b0001110) begin failures++; $display("FAIL to_rsp: got %b exp 0001110", {rsp_valid, rsp_error, rsp_timeout, ctrl_ready}); end
        set_client(3, 7'h3A, 8'h99);
        req_valid = 4'b1000;
        wait_grant(ok);
        req_valid = 4'b0000;
        checks++; if (!ok || grant_id !== 2'd3) begin failures++; $display("FAIL to_next_grant: got ok %b id %0d exp 3", ok, grant_id); end
        serve(2, 1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if ({rsp_valid, rsp_data, rsp_error, rsp_timeout} !== {4'b1000, 8'h5A, 2'b00}) begin failures++; $display("FAIL to_next_rsp: got %h exp %h", {rsp_valid, rsp_data, rsp_error, rsp_timeout}, {4'b1000, 8'h5A, 2'b00}); end
        tick(); tick();
    endtask

    task automatic test_same_cycle();
        bit ok;
        set_client(2, 7'h51, 8'h0F);
        req_valid = 4'b0100;
        wait_grant(ok);
        req_valid = 4'b0000;
        checks++; if (!ok || grant_id !== 2'd2) begin failures++; $display("FAIL same_grant: got ok %b id %0d exp 2", ok, grant_id); end
        serve(1, 1'b1, 8'h81, 1'b1, 1'b0);
        checks++; if ({rsp_valid, rsp_data, rsp_error} !== {4'b0100, 8'h81, 1'b0}) begin failures++; $display("FAIL same_rsp: got %h exp %h", {rsp_valid, rsp_data, rsp_error}, {4'b0100, 8'h81, 1'b0}); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        req_valid = 4'b0010;
        wait_grant(ok);
        req_valid = 4'b0000;
        tick();
        checks++; if (ctrl_ready !== 1'b1) begin failures++; $display("FAIL rm_wait_ready: got %b exp 1", ctrl_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ctrl_ready, arb_busy} !== 2'b00) begin failures++; $display("FAIL rm_wait_async: got %b exp 00", {ctrl_ready, arb_busy}); end
        tick();
        rst_n = 1'b1;
        tick();
        req_valid = 4'b0010;
        wait_grant(ok);
        req_valid = 4'b0000;
        tick();
        ctrl_busy = 1'b1;
        tick();
        checks++; if ({arb_busy, ctrl_ready} !== 2'b10) begin failures++; $display("FAIL rm_active: got %b exp 10", {arb_busy, ctrl_ready}); end
        tick();
        #2 rst_n = 1'b0;
        ctrl_busy = 1'b0;
        #1;
        checks++; if ({ctrl_ready, arb_busy, grant_id} !== 4'b0000) begin failures++; $display("FAIL rm_active_async: got %b exp 0000", {ctrl_ready, arb_busy, grant_id}); end
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen |= |rsp_valid;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rm_no_rsp: got %b exp 0", seen); end
        req_valid = 4'b0011;
        wait_grant(ok);
        req_valid = 4'b0000;
        checks++; if (!ok || {grant_id, req_ready} !== {2'd0, 4'b0001}) begin failures++; $display("FAIL rm_priority: got ok %b id %0d ready %b exp id 0", ok, grant_id, req_ready); end
        serve(1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        ctrl_rx_data = 8'hEE; ctrl_valid = 1'b0; ctrl_busy = 1'b0; ctrl_ack_error = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ack_error();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter that shares one `controller` (I2C master) between NUM_REQ client blocks. Each client posts a transaction (slave address plus tx byte). The arbiter grants one client at a time, drives the controller's request inputs, and watches controller busy/valid to detect completion. It then returns rx data and error status to the granted client only. It sits between the client logic and the single I2C master instance.

## Interface
- NUM_REQ, 4, number of clients (2..8)
- ADDR_WIDTH, 7, I2C slave address width
- DATA_WIDTH, 8, data byte width
- START_TIMEOUT, 255, max cycles to wait for ctrl_busy after launch
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  client i has a pending transaction; held until req_ready[i]
- req_addr  in  NUM_REQ*ADDR_WIDTH  client i address in slice i
- req_data  in  NUM_REQ*DATA_WIDTH  client i tx byte in slice i
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_data  out  DATA_WIDTH  rx byte; valid only with rsp_valid
- rsp_error  out  1  ack error or timeout; valid only with rsp_valid
- rsp_timeout  out  1  controller never went busy; valid only with rsp_valid
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted client
- arb_busy  out  1  high in every state except IDLE
- ctrl_slave_addr  out  ADDR_WIDTH  to controller slave_addr
- ctrl_tx_data  out  DATA_WIDTH  to controller tx_data
- ctrl_ready  out  1  to controller ready
- ctrl_rx_data  in  DATA_WIDTH  from controller rx_data
- ctrl_valid  in  1  from controller valid
- ctrl_busy  in  1  from controller busy
- ctrl_ack_error  in  1  from controller ack_error

## Operation
FSM states: IDLE, LAUNCH, WAIT_BUSY, ACTIVE, RESPOND.
- **IDLE:** if any req_valid is set and ctrl_busy=0, select the first set bit scanning from last_grant+1 upward with wrap. Latch its addr/data into ctrl_slave_addr/ctrl_tx_data, set grant_id, clear the rx capture register to 0, go to LAUNCH. If ctrl_busy=1, stay in IDLE.
- **LAUNCH (1 cycle):** req_ready[grant_id]=1, ctrl_ready=1, clear the timeout counter, go to WAIT_BUSY.
- **WAIT_BUSY:** ctrl_ready stays 1 and the counter increments each cycle.
  - ctrl_busy=1 → ACTIVE, with ctrl_ready=0 from that cycle onward.
  - counter reaches START_TIMEOUT → RESPOND with the timeout flag set.
- **ACTIVE:** ctrl_valid=1 latches ctrl_rx_data into the capture register. ctrl_busy=0 → RESPOND, with ctrl_ack_error sampled that same cycle. If ctrl_valid and the busy fall occur in the same cycle, the data is still captured.
- **RESPOND (1 cycle):**
  - rsp_valid[grant_id]=1, rsp_data=capture register.
  - rsp_timeout=flag, rsp_error=sampled ack_error OR flag.
  - last_grant←grant_id, go to IDLE.
- ctrl_slave_addr/ctrl_tx_data are stable from LAUNCH through RESPOND.
- The grant decision is made only in IDLE. Requests dropped after acceptance are still executed to completion.
- A client holding req_valid after its req_ready pulse is treated as a new request. It competes in the next IDLE.
- Width rules:
  - Timeout counter width is $clog2(START_TIMEOUT+1). It saturates and does not wrap.
  - Pointer wrap: index NUM_REQ-1 is followed by index 0.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: all 0 (req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout, grant_id, arb_busy, ctrl_ready, ctrl_slave_addr, ctrl_tx_data).
  - last_grant=NUM_REQ-1, so client 0 has first priority.
- Asserting reset mid-transaction forces IDLE and drops ctrl_ready asynchronously. No rsp_valid is issued for the aborted transaction.
- All outputs are registered (no combinational input→output paths).
- A request is sampled in IDLE at cycle N. req_ready and ctrl_ready go high at N+1. The earliest cycle WAIT_BUSY can see ctrl_busy is N+2.
- If ctrl_busy never rises, rsp_valid occurs at N+2+START_TIMEOUT.
- Otherwise rsp_valid occurs one cycle after the cycle in which ACTIVE sees ctrl_busy=0.
- Minimum gap between consecutive grants is 1 IDLE cycle after RESPOND.

## Test plan
- **Single request:** req_valid[2]=1, addr 0x50, data 0xA5; bench controller raises busy 3 cycles after ready, pulses valid with rx 0x3C, drops busy → req_ready[2] one cycle; ctrl_slave_addr=0x50 and ctrl_tx_data=0xA5 stable; rsp_valid[2] with rsp_data=0x3C, rsp_error=0.
- **Round-robin:** clients 0, 1, 3 request simultaneously after reset and keep requesting → grant order 0, 1, 3, 0, 1, 3; no client granted twice while another waits.
- **Ack error:** ctrl_ack_error=1 on the busy-fall cycle → rsp_error=1, rsp_timeout=0, rsp_data=0 (no ctrl_valid seen).
- **Start timeout:** ctrl_busy held 0, START_TIMEOUT=10 → ctrl_ready high from N+1 through the timeout cycle; rsp_valid at N+12 with rsp_error=1, rsp_timeout=1; next request granted normally.
- **Same-cycle data and busy fall:** ctrl_valid=1 with rx 0x81 in the same cycle ctrl_busy falls → rsp_data=0x81.
- **Reset mid-transaction:** reset asserted during ACTIVE → ctrl_ready=0 and arb_busy=0 immediately; no rsp_valid; after release, client 0 wins a simultaneous request from 0 and 1.
